// File: rtl/seq_detect_1011.sv
// Serial "1011" pattern detector with registered detect pulse and saturating hit counter.
// Define SEQ_DETECT_OVERLAP_EN for overlapping detection; the default build is non-overlapping.
module seq_detect_1011 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             enable,
    input  logic             clear,
    output logic             detect,
    output logic [CNT_W-1:0] hit_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            S0:    if (enable) state_d = in_bit ? S1    : S0;
            S1:    if (enable) state_d = in_bit ? S1    : S10;
            S10:   if (enable) state_d = in_bit ? S101  : S0;
            S101:  if (enable) state_d = in_bit ? S1011 : S10;
`ifdef SEQ_DETECT_OVERLAP_EN
            S1011: if (enable) state_d = in_bit ? S1    : S10;
`else
            S1011: if (enable) state_d = in_bit ? S1    : S0;
`endif
            // Encodings 5..7 recover to S0 on the next edge even while enable is low.
            default: state_d = S0;
        endcase
    end

    // The only way into S1011 is a sampled '1' from S101, so detect never repeats while held there.
    assign detect_d = enable && (state_q == S101) && in_bit;

    always_comb begin
        hit_count_d = hit_count_q;
        if (clear) begin
            hit_count_d = '0;
        end else if (detect_d && (hit_count_q != {CNT_W{1'b1}})) begin
            hit_count_d = hit_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S0;
            detect_q    <= 1'b0;
            hit_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            detect_q    <= detect_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign detect    = detect_q;
    assign hit_count = hit_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Self-checking bench for seq_detect_1011: directed vector table, reset/saturation sequences,
// and an upstream DFF chain compared against a history-based reference model.
module tb_seq_detect_1011;

`ifdef SEQ_DETECT_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear;
    logic       in_drv;
    logic       in_bit;
    logic       chain_on;
    logic       chain_d;
    logic       chain_q;

    logic       det8, det2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [2:0] st8, st2;

    int checks   = 0;
    int failures = 0;

    assign in_bit = chain_on ? chain_q : in_drv;

    seq_detect_1011 #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_bit(in_bit), .enable(enable), .clear(clear),
        .detect(det8), .hit_count(cnt8), .state_dbg(st8)
    );

    seq_detect_1011 #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_bit(in_bit), .enable(enable), .clear(clear),
        .detect(det2), .hit_count(cnt2), .state_dbg(st2)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Upstream stage: D toggles every 13 ns, Q captured on the same clock as the detector.
    initial chain_d = 1'b0;
    always begin
        #13;
        chain_d <= ~chain_d;
    end
    always @(posedge clk) chain_q <= chain_d;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic b);
        @(negedge clk);
        enable = en;
        clear  = clr;
        in_drv = b;
        @(posedge clk);
        #1;
    endtask

    task automatic feed1011();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        in_drv = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       clr;
        logic       b;
        logic       det;
        logic [2:0] st;
        logic [7:0] cnt;
    } vec_t;

    function automatic vec_t mk(input int en, input int clr, input int b,
                                input int det, input int st, input int cnt);
        vec_t v;
        v.en  = en[0];
        v.clr = clr[0];
        v.b   = b[0];
        v.det = det[0];
        v.st  = 3'(st);
        v.cnt = 8'(cnt);
        return v;
    endfunction

    // Reference model: last four sampled bits; a non-overlapping match discards the history.
    logic [3:0] m_hist;
    int         m_len;
    int         m_count;
    logic [2:0] m_state;

    task automatic model_reset();
        m_hist  = 4'b0000;
        m_len   = 0;
        m_count = 0;
        m_state = 3'd0;
    endtask

    task automatic model_step(input logic b);
        logic [3:0] pat;
        logic       ok;
        pat    = 4'b1011;
        m_hist = {m_hist[2:0], b};
        if (m_len < 4) m_len++;
        m_state = 3'd0;
        for (int k = 4; k >= 1; k--) begin
            ok = (m_len >= k);
            for (int j = 0; j < k; j++) begin
                if (m_hist[k-1-j] != pat[3-j]) ok = 1'b0;
            end
            if (ok && m_state == 3'd0) m_state = 3'(k);
        end
        if (m_state == 3'd4) begin
            m_count++;
            if (!OV) m_len = 0;
        end
    endtask

    vec_t vecs[24];
    int   c1, c2, pulses, sat;

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        in_drv   = 1'b0;
        chain_on = 1'b0;
        #1;
        check("reset_state", 32'(st8), 0);
        check("reset_detect", 32'(det8), 0);
        check("reset_count", 32'(cnt8), 0);
        check("reset_count_w2", 32'(cnt2), 0);

        c1 = OV ? 2 : 1;
        c2 = OV ? 3 : 2;
        vecs[0]  = mk(1, 0, 1, 0, 1, 0);
        vecs[1]  = mk(1, 0, 0, 0, 2, 0);
        vecs[2]  = mk(1, 0, 1, 0, 3, 0);
        vecs[3]  = mk(1, 0, 1, 1, 4, 1);
        vecs[4]  = mk(1, 0, 0, 0, OV ? 2 : 0, 1);
        vecs[5]  = mk(1, 0, 1, 0, OV ? 3 : 1, 1);
        vecs[6]  = mk(1, 0, 1, OV ? 1 : 0, OV ? 4 : 1, c1);
        vecs[7]  = mk(1, 0, 1, 0, 1, c1);
        vecs[8]  = mk(1, 0, 0, 0, 2, c1);
        vecs[9]  = mk(0, 0, 1, 0, 2, c1);
        vecs[10] = mk(0, 0, 0, 0, 2, c1);
        vecs[11] = mk(0, 0, 1, 0, 2, c1);
        vecs[12] = mk(0, 0, 0, 0, 2, c1);
        vecs[13] = mk(0, 0, 1, 0, 2, c1);
        vecs[14] = mk(1, 0, 1, 0, 3, c1);
        vecs[15] = mk(1, 0, 1, 1, 4, c2);
        vecs[16] = mk(0, 0, 1, 0, 4, c2);
        vecs[17] = mk(0, 1, 0, 0, 4, 0);
        vecs[18] = mk(1, 0, 0, 0, OV ? 2 : 0, 0);
        vecs[19] = mk(1, 0, 1, 0, OV ? 3 : 1, 0);
        vecs[20] = mk(1, 0, 0, 0, 2, 0);
        vecs[21] = mk(1, 0, 1, 0, 3, 0);
        vecs[22] = mk(1, 1, 1, 1, 4, 0);
        vecs[23] = mk(1, 0, 1, 0, 1, 0);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].b);
            check($sformatf("vec%0d_detect", i), 32'(det8), 32'(vecs[i].det));
            check($sformatf("vec%0d_state", i), 32'(st8), 32'(vecs[i].st));
            check($sformatf("vec%0d_count", i), 32'(cnt8), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_count_w2", i), 32'(cnt2), 32'(vecs[i].cnt));
        end

        // Asynchronous reset in S101 with three hits recorded.
        do_reset();
        repeat (3) feed1011();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("pre_reset_state", 32'(st8), 3);
        check("pre_reset_count", 32'(cnt8), 3);
        #5 reset = 1'b0;
        #1;
        check("async_reset_state", 32'(st8), 0);
        check("async_reset_detect", 32'(det8), 0);
        check("async_reset_count", 32'(cnt8), 0);
        check("async_reset_count_w2", 32'(cnt2), 0);
        @(posedge clk);
        #1;
        check("reset_hold_state", 32'(st8), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        check("post_reset_state", 32'(st8), 1);
        check("post_reset_detect", 32'(det8), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("post_reset_hit", 32'(det8), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_detect_hi", 32'(det8), 0);
        @(negedge clk);
        reset = 1'b1;

        // Saturation on the 2-bit counter, then clear racing a detection.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            feed1011();
            sat = (k > 3) ? 3 : k;
            check($sformatf("sat%0d_detect", k), 32'(det2), 1);
            check($sformatf("sat%0d_count_w2", k), 32'(cnt2), 32'(sat));
            check($sformatf("sat%0d_count", k), 32'(cnt8), 32'(k));
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("clear_vs_hit_detect", 32'(det2), 1);
        check("clear_vs_hit_count_w2", 32'(cnt2), 0);
        check("clear_vs_hit_count", 32'(cnt8), 0);
        check("clear_vs_hit_state", 32'(st2), 4);
        step(1'b1, 1'b0, 1'b0);
        check("pulse_width", 32'(det2), 0);

        // Upstream DFF chain against the reference model.
        do_reset();
        model_reset();
        pulses   = 0;
        chain_on = 1'b1;
        enable   = 1'b1;
        #1;
        for (int i = 0; i < 250; i++) begin
            model_step(in_bit);
            @(negedge clk);
            check("chain_state", 32'(st8), 32'(m_state));
            if (det8) pulses++;
        end
        check("chain_count", 32'(cnt8), 32'(m_count));
        check("chain_pulses", 32'(pulses), 32'(m_count));
        check("chain_count_w2", 32'(cnt2), 32'((m_count > 3) ? 3 : m_count));
        chain_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
